// File: rtl/bitfusion_pkg.sv
// Shared types, default widths and the partial-sum extension helper for the
// psum_accumulator slice.
package bitfusion_pkg;

    localparam int DEF_PSUM_W = 8;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_LEN_W  = 8;
    // Fixed working width of ext_psum; callers truncate to their ACC_W.
    localparam int EXT_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    // Sign- (s=1) or zero-extends the low psum_w bits of psum to EXT_W bits.
    function automatic logic [EXT_W-1:0] ext_psum(input logic [EXT_W-1:0] psum,
                                                  input int unsigned       psum_w,
                                                  input logic              s);
        logic [EXT_W-1:0] field_mask;
        logic [EXT_W-1:0] sign_bit;
        field_mask = (EXT_W'(1) << psum_w) - EXT_W'(1);
        sign_bit   = EXT_W'(1) << (psum_w - 1);
        return ((s && |(psum & sign_bit)) ? ~field_mask : '0) | (psum & field_mask);
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Partial-sum input stream plus result output stream of psum_accumulator.
// slave = accumulator view, master = producer/consumer view.
interface psum_accumulator_if #(
    parameter int PSUM_W = 8,
    parameter int ACC_W  = 20
);
    logic              psum_valid;
    logic              psum_ready;
    logic [PSUM_W-1:0] psum;
    logic              s_psum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    modport slave (
        input  psum_valid, psum, s_psum, out_ready,
        output psum_ready, out_valid, out_data
    );

    modport master (
        output psum_valid, psum, s_psum, out_ready,
        input  psum_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_acc_add.sv
// Combinational signed ACC_W adder with overflow detect. With PSUM_SATURATE_EN
// defined the sum clamps to the signed range on overflow; otherwise it wraps.
module psum_acc_add
    import bitfusion_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef PSUM_SATURATE_EN
        // Both operands share a sign on overflow, so a's sign picks the rail.
        if (ovf) begin
            sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a programmed number of partial-sum beats into one signed result word.
// Optional PSUM_SATURATE_EN selects saturating instead of wrapping accumulation.
module psum_accumulator
    import bitfusion_pkg::*;
#(
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    psum_accumulator_if.slave bus,
    output logic             busy,
    output logic             ovf,
    output logic             cfg_err
);
    state_t           state_q,      state_d;
    logic [LEN_W-1:0] len_q,        len_d;
    logic [LEN_W-1:0] count_q,      count_d;
    logic [ACC_W-1:0] acc_q,        acc_d;
    logic [ACC_W-1:0] out_data_q,   out_data_d;
    logic             psum_ready_q, psum_ready_d;
    logic             out_valid_q,  out_valid_d;
    logic             busy_q,       busy_d;
    logic             ovf_q,        ovf_d;
    logic             cfg_err_q,    cfg_err_d;

    logic [ACC_W-1:0] psum_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             beat;

    assign psum_ext = ACC_W'(ext_psum(EXT_W'(bus.psum), PSUM_W, bus.s_psum));
    assign beat     = bus.psum_valid && psum_ready_q;

    psum_acc_add #(.ACC_W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (psum_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        // NOTE: every _d starts as its hold value so no path leaves it unassigned (no latches).
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        cfg_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_len != '0) begin
                        len_d   = cfg_len;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = add_sum;
                    count_d = count_q + LEN_W'(1);
                    if (add_ovf) ovf_d = 1'b1;
                    if (count_q == len_q - LEN_W'(1)) begin
                        out_data_d = add_sum;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered decodes of the next state.
        psum_ready_d = (state_d == ACCUM);
        out_valid_d  = (state_d == DRAIN);
        busy_d       = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            count_q      <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            psum_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            psum_ready_q <= psum_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.psum_ready = psum_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign busy           = busy_q;
    assign ovf            = ovf_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: a default ACC_W=20 instance with
// randomized transactions, plus an ACC_W=9 instance for overflow behaviour.
module tb_psum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, s_cfg_start;
    logic [7:0] cfg_len,   s_cfg_len;
    logic       busy, ovf, cfg_err;
    logic       s_busy, s_ovf, s_cfg_err;

    int total = 0;
    int bad   = 0;

    int q_val[$];
    bit q_sgn[$];

    psum_accumulator_if #(.PSUM_W(8), .ACC_W(20)) bus ();
    psum_accumulator_if #(.PSUM_W(8), .ACC_W(9))  sbus ();

    psum_accumulator #(.PSUM_W(8), .ACC_W(20), .LEN_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_len   (cfg_len),
        .bus       (bus),
        .busy      (busy),
        .ovf       (ovf),
        .cfg_err   (cfg_err)
    );

    psum_accumulator #(.PSUM_W(8), .ACC_W(9), .LEN_W(8)) u_small (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (s_cfg_start),
        .cfg_len   (s_cfg_len),
        .bus       (sbus),
        .busy      (s_busy),
        .ovf       (s_ovf),
        .cfg_err   (s_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer running sum, range-checked against a w-bit signed
    // accumulator after every beat, then wrapped or clamped.
    function automatic void ref_sum(input int w, output logic [63:0] res, output bit ovf_exp);
        longint half = longint'(1) << (w - 1);
        longint acc  = 0;
        longint v;
        longint x;
        ovf_exp = 1'b0;
        foreach (q_val[i]) begin
            v = (q_sgn[i] && q_val[i] >= 128) ? longint'(q_val[i] - 256) : longint'(q_val[i]);
            x = acc + v;
            if (x > half - 1 || x < -half) begin
                ovf_exp = 1'b1;
`ifdef PSUM_SATURATE_EN
                x = (x > 0) ? half - 1 : -half;
`else
                x = (x > 0) ? x - 2 * half : x + 2 * half;
`endif
            end
            acc = x;
        end
        res = 64'(acc) & ((64'(1) << w) - 64'(1));
    endfunction

    function automatic void fill_rand(input int len, input int mode);
        q_val.delete();
        q_sgn.delete();
        for (int i = 0; i < len; i++) begin
            q_val.push_back(int'($urandom_range(255)));
            q_sgn.push_back(mode == 2 ? 1'($urandom) : 1'(mode));
        end
    endfunction

    task automatic run_txn(input int drain_wait, input int valid_pct, input bit poke_start);
        int          len = q_val.size();
        int          idx = 0;
        int          cyc = 0;
        logic [63:0] exp;
        bit          exp_ovf;
        ref_sum(20, exp, exp_ovf);

        cfg_start = 1'b1;
        cfg_len   = 8'(len);
        @(negedge clk);
        cfg_start = 1'b0;
        check("start_busy",  64'(busy), 64'd1);
        check("start_ready", 64'(bus.psum_ready), 64'd1);
        check("start_ovf",   64'(ovf), 64'd0);

        while (idx < len && cyc < 40 * len + 50) begin
            if (int'($urandom_range(99)) < valid_pct) begin
                bus.psum_valid = 1'b1;
                bus.psum       = 8'(q_val[idx]);
                bus.s_psum     = q_sgn[idx];
            end else begin
                bus.psum_valid = 1'b0;
                bus.psum       = 8'($urandom);
                bus.s_psum     = 1'($urandom);
            end
            cfg_start = poke_start && ($urandom_range(3) == 0);
            cfg_len   = 8'($urandom_range(1, 255));
            @(negedge clk);
            if (bus.psum_valid) idx++;
            cyc++;
        end
        bus.psum_valid = 1'b0;
        cfg_start      = 1'b0;
        check("beat_budget", 64'(idx), 64'(len));

        check("res_valid", 64'(bus.out_valid), 64'd1);
        check("res_data",  64'(bus.out_data), exp);
        check("res_ovf",   64'(ovf), 64'(exp_ovf));
        check("res_ready", 64'(bus.psum_ready), 64'd0);

        for (int k = 0; k < drain_wait; k++) begin
            bus.out_ready  = 1'b0;
            bus.psum_valid = 1'b1;
            bus.psum       = 8'($urandom);
            cfg_start      = poke_start;
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_data",  64'(bus.out_data), exp);
            check("hold_ready", 64'(bus.psum_ready), 64'd0);
        end
        bus.psum_valid = 1'b0;
        cfg_start      = 1'b0;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drop_valid", 64'(bus.out_valid), 64'd0);
        check("idle_busy",  64'(busy), 64'd0);
        check("ovf_sticky", 64'(ovf), 64'(exp_ovf));
    endtask

    task automatic run_small();
        logic [63:0] exp;
        bit          exp_ovf;
        ref_sum(9, exp, exp_ovf);
        s_cfg_start = 1'b1;
        s_cfg_len   = 8'(q_val.size());
        @(negedge clk);
        s_cfg_start = 1'b0;
        check("s_start_ovf", 64'(s_ovf), 64'd0);
        foreach (q_val[i]) begin
            sbus.psum_valid = 1'b1;
            sbus.psum       = 8'(q_val[i]);
            sbus.s_psum     = q_sgn[i];
            @(negedge clk);
        end
        sbus.psum_valid = 1'b0;
        check("s_valid", 64'(sbus.out_valid), 64'd1);
        check("s_data",  64'(sbus.out_data), exp);
        check("s_ovf",   64'(s_ovf), 64'(exp_ovf));
        sbus.out_ready = 1'b1;
        @(negedge clk);
        sbus.out_ready = 1'b0;
        check("s_drop",   64'(sbus.out_valid), 64'd0);
        check("s_sticky", 64'(s_ovf), 64'(exp_ovf));
    endtask

    initial begin
        rst             = 1'b1;
        cfg_start       = 1'b0;
        cfg_len         = 8'd0;
        s_cfg_start     = 1'b0;
        s_cfg_len       = 8'd0;
        bus.psum_valid  = 1'b0;
        bus.psum        = 8'd0;
        bus.s_psum      = 1'b0;
        bus.out_ready   = 1'b0;
        sbus.psum_valid = 1'b0;
        sbus.psum       = 8'd0;
        sbus.s_psum     = 1'b0;
        sbus.out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ready", 64'(bus.psum_ready), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data",  64'(bus.out_data), 64'd0);
        check("rst_ovf",   64'(ovf), 64'd0);
        check("rst_err",   64'(cfg_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned back-to-back beats.
        q_val = '{3, 5, 7, 9};
        q_sgn = '{0, 0, 0, 0};
        run_txn(0, 100, 1'b0);

        // Same beats interpreted signed, then unsigned.
        q_val = '{255, 254, 5};
        q_sgn = '{1, 1, 1};
        run_txn(0, 100, 1'b0);
        q_sgn = '{0, 0, 0};
        run_txn(5, 100, 1'b0);

        // Narrow accumulator: positive and negative overflow, then a clean result.
        q_val = '{127, 127, 127};
        q_sgn = '{1, 1, 1};
        run_small();
        q_val = '{128, 128, 128};
        run_small();
        q_val = '{100, 20, 200};
        q_sgn = '{0, 0, 1};
        run_small();

        // Zero length is rejected with a single-cycle error pulse.
        cfg_start = 1'b1;
        cfg_len   = 8'd0;
        @(negedge clk);
        cfg_start = 1'b0;
        check("err_pulse", 64'(cfg_err), 64'd1);
        check("err_busy",  64'(busy), 64'd0);
        @(negedge clk);
        check("err_clear", 64'(cfg_err), 64'd0);

        // Reset mid-accumulation discards the partial sum.
        cfg_start = 1'b1;
        cfg_len   = 8'd4;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.psum_valid = 1'b1;
            bus.psum       = 8'd50;
            bus.s_psum     = 1'b0;
            @(negedge clk);
        end
        bus.psum_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_ready", 64'(bus.psum_ready), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_data",  64'(bus.out_data), 64'd0);
        check("mid_rst_ovf",   64'(ovf), 64'd0);

        // Gappy stream with ignored cfg_start pulses, then length extremes.
        fill_rand(6, 2);
        run_txn(2, 50, 1'b1);
        fill_rand(1, 1);
        run_txn(1, 100, 1'b1);
        fill_rand(255, 0);
        run_txn(0, 100, 1'b0);

        for (int t = 0; t < 30; t++) begin
            fill_rand(int'($urandom_range(1, 24)), int'($urandom_range(2)));
            run_txn(int'($urandom_range(3)), int'($urandom_range(40, 100)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
